// File: rtl/msg_reporter.sv
// ----------------------------------------------------------------------------
// msg_reporter
//   Sits downstream of the RC4 key-search FSM. When the search finishes with
//   a key, it reads MSG_LEN decrypted bytes from d_memory through that RAM's
//   spare read port and streams them over a valid/ready byte link to the
//   character/LCD driver. When the search fails, it raises a sticky fail flag
//   and sends nothing.
//
//   Optional feature macro: HEX_DISPLAY_EN
//     defined   : hex5..hex0 show the latched key (hex5 = key[23:20]),
//                 active-low 7-segment, or '-' on every digit after a fail.
//     undefined : hex ports are tied blank (7'h7F); no key register is built.
//
// Ports
//   clk          in   1       system clock, all logic on posedge
//   reset        in   1       synchronous, active-high
//   search_done  in   1       key search finished (level)
//   cracked      in   1       search found a key, valid with search_done
//   secret_key   in   24      found key
//   mem_addr     out  ADDR_W  d_memory read address
//   mem_q        in   8       d_memory read data, RD_LAT cycles after mem_addr
//   char_data    out  8       decrypted byte
//   char_valid   out  1       char_data valid
//   char_ready   in   1       sink accepts byte
//   busy         out  1       streaming in progress
//   complete     out  1       all bytes accepted (sticky)
//   fail         out  1       search ended without a key (sticky)
//   hex0..hex5   out  7 each  active-low 7-segment digits
// ----------------------------------------------------------------------------
module msg_reporter #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              search_done,
    input  logic              cracked,
    input  logic [23:0]       secret_key,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic [7:0]        char_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              complete,
    output logic              fail,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_char_data;
    logic               r_char_valid;
    logic               r_busy;
    logic               r_complete;
    logic               r_fail;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_char_data  <= '0;
            r_char_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_complete   <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (search_done) begin
                        if (cracked) begin
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end else begin
                            r_fail  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    r_mem_addr <= r_idx[ADDR_W-1:0];
                    r_cnt      <= CNT_W'(RD_LAT);
                    r_state    <= S_WAIT;
                end
                // Leaving on count==1 spends exactly RD_LAT cycles here, so the
                // CAPTURE edge samples mem_q a full RD_LAT cycles after the
                // address settled.
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_char_data  <= mem_q;
                    r_char_valid <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (char_ready) begin
                        r_char_valid <= 1'b0;
                        if (r_idx == IDX_W'(MSG_LEN - 1)) begin
                            r_complete <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign char_data  = r_char_data;
    assign char_valid = r_char_valid;
    assign busy       = r_busy;
    assign complete   = r_complete;
    assign fail       = r_fail;

`ifdef HEX_DISPLAY_EN
    logic [23:0] r_key_q;
    logic        r_key_valid;
    logic [6:0]  w_hex [6];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_q     <= '0;
            r_key_valid <= 1'b0;
        end else if (r_state == S_IDLE && search_done && cracked) begin
            r_key_q     <= secret_key;
            r_key_valid <= 1'b1;
        end
    end

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] f_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 6; i++) begin
            w_hex[i] = 7'h7F;
            if (r_fail) begin
                w_hex[i] = 7'h3F;
            end else if (r_key_valid) begin
                w_hex[i] = f_seg(r_key_q[4*i +: 4]);
            end
        end
    end

    assign hex0 = w_hex[0];
    assign hex1 = w_hex[1];
    assign hex2 = w_hex[2];
    assign hex3 = w_hex[3];
    assign hex4 = w_hex[4];
    assign hex5 = w_hex[5];
`else
    logic w_unused_key;
    assign w_unused_key = ^secret_key;

    assign hex0 = 7'h7F;
    assign hex1 = 7'h7F;
    assign hex2 = 7'h7F;
    assign hex3 = 7'h7F;
    assign hex4 = 7'h7F;
    assign hex5 = 7'h7F;
`endif

endmodule

// File: tb/tb_msg_reporter.sv
module tb_msg_reporter;

    logic        clk;
    logic        reset;
    logic        search_done;
    logic        cracked;
    logic [23:0] secret_key;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_q;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        complete;
    logic        fail;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_vec = 0;
    int n_err = 0;

`ifdef HEX_DISPLAY_EN
    localparam bit HEX_ON = 1'b1;
`else
    localparam bit HEX_ON = 1'b0;
`endif

    msg_reporter #(.MSG_LEN(32), .ADDR_W(8), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset), .search_done(search_done), .cracked(cracked),
        .secret_key(secret_key), .mem_addr(mem_addr), .mem_q(mem_q),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .busy(busy), .complete(complete), .fail(fail),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d_memory model: RAM[k] = 'a' + k%26, two-cycle registered read.
    function automatic logic [7:0] ram_val(input int k);
        return 8'h61 + 8'(k % 26);
    endfunction

    logic [7:0] p1, p2;
    always @(posedge clk) begin
        p1 <= ram_val(int'(mem_addr));
        p2 <= p1;
    end
    assign mem_q = p2;

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_hex(input string name, input logic [41:0] exp_on);
        chk(name, {hex5, hex4, hex3, hex2, hex1, hex0}, HEX_ON ? exp_on : {6{7'h7F}});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; search_done = 1'b0; cracked = 1'b0; char_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Streams one message; optional stall on one byte, reset during one
    // byte, or cracked dropped mid-stream. Returns bytes transferred.
    task automatic stream(input int stall_byte, input int reset_byte,
                          input bit drop_cracked, output int n_out);
        int n = 0, cyc = 0, last = -1, stall = 0;
        logic v, r;
        logic [7:0] d;
        search_done = 1'b1; cracked = 1'b1; char_ready = 1'b1;
        while (n < 32 && cyc < 2000) begin
            if (drop_cracked && n == 5) cracked = 1'b0;
            if (n == reset_byte && char_valid) begin
                reset = 1'b1; search_done = 1'b0;
                tick();
                reset = 1'b0;
                chk("rst_mid", {mem_addr, char_data, char_valid, busy, complete, fail},
                    {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
                chk_hex("rst_mid_hex", {6{7'h7F}});
                repeat (3) tick();
                chk("rst_idle_wait", {char_valid, busy}, 2'b00);
                n_out = n;
                return;
            end
            if (n == stall_byte && char_valid && stall < 10) begin
                char_ready = 1'b0;
                chk("stall_hold", {char_valid, char_data}, {1'b1, ram_val(n)});
                stall++;
            end else begin
                char_ready = 1'b1;
            end
            v = char_valid; d = char_data; r = char_ready;
            tick();
            cyc++;
            if (v && r) begin
                chk("byte_data", d, ram_val(n));
                if (stall_byte < 0 && last >= 0) chk("byte_spacing", cyc - last, 5);
                last = cyc;
                if (n == stall_byte) begin
                    chk("stall_count", stall, 10);
                    tick();
                    cyc++;
                    chk("addr_after_stall", mem_addr, 8'(n + 1));
                end
                n++;
            end
        end
        n_out = n;
    endtask

    typedef struct {
        logic       rst, sd, cr, rdy;
        logic [7:0] addr;
        logic       vld;
        logic [7:0] data;
        logic       bsy, cmp, fl;
    } vec_t;

    function automatic vec_t mk(input logic rst, sd, cr, rdy, input logic [7:0] addr,
                                input logic vld, input logic [7:0] data, input logic bsy);
        vec_t x;
        x.rst = rst; x.sd = sd; x.cr = cr; x.rdy = rdy;
        x.addr = addr; x.vld = vld; x.data = data; x.bsy = bsy; x.cmp = 1'b0; x.fl = 1'b0;
        return x;
    endfunction

    initial begin
        vec_t tbl[14];
        int nb;
        reset = 1'b1; search_done = 1'b0; cracked = 1'b0; char_ready = 1'b0;
        secret_key = 24'h2A3F1C;

        // Cycle-exact opening of a stream: expectations after each posedge.
        tbl[0]  = mk(1, 0, 0, 0, 8'd0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 1, 1, 1, 8'd0, 0, 8'h00, 1);
        tbl[2]  = mk(0, 1, 1, 1, 8'd0, 0, 8'h00, 1);
        tbl[3]  = mk(0, 1, 1, 1, 8'd0, 0, 8'h00, 1);
        tbl[4]  = mk(0, 1, 1, 1, 8'd0, 0, 8'h00, 1);
        tbl[5]  = mk(0, 1, 1, 1, 8'd0, 1, 8'h61, 1);
        tbl[6]  = mk(0, 1, 1, 1, 8'd0, 0, 8'h61, 1);
        tbl[7]  = mk(0, 1, 1, 1, 8'd1, 0, 8'h61, 1);
        tbl[8]  = mk(0, 1, 1, 1, 8'd1, 0, 8'h61, 1);
        tbl[9]  = mk(0, 1, 1, 1, 8'd1, 0, 8'h61, 1);
        tbl[10] = mk(0, 1, 1, 1, 8'd1, 1, 8'h62, 1);
        tbl[11] = mk(0, 1, 1, 0, 8'd1, 1, 8'h62, 1);
        tbl[12] = mk(0, 1, 1, 1, 8'd1, 0, 8'h62, 1);
        tbl[13] = mk(0, 1, 1, 1, 8'd2, 0, 8'h62, 1);

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; search_done = tbl[i].sd;
            cracked = tbl[i].cr; char_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d", i),
                {mem_addr, char_data, char_valid, busy, complete, fail},
                {tbl[i].addr, tbl[i].data, tbl[i].vld, tbl[i].bsy, tbl[i].cmp, tbl[i].fl});
        end
        chk_hex("hex_key_2A3F1C", {7'h24, 7'h08, 7'h30, 7'h0E, 7'h79, 7'h46});

        // Full message with ready tied high.
        do_reset();
        chk_hex("hex_reset", {6{7'h7F}});
        stream(-1, -1, 1'b0, nb);
        chk("full_count", nb, 32);
        chk("full_end", {busy, complete, fail}, 3'b010);
        repeat (5) tick();
        chk("done_hold", {char_valid, busy, complete, fail}, 4'b0010);

        // Fail path, including a late cracked that must be ignored.
        do_reset();
        search_done = 1'b1; cracked = 1'b0;
        tick();
        chk("fail_set", {fail, complete, busy}, 3'b100);
        chk_hex("hex_fail", {6{7'h3F}});
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) cracked = 1'b1;
            tick();
            if (char_valid || busy || complete) nb++;
        end
        chk("fail_quiet", nb, 0);
        chk("fail_sticky", fail, 1'b1);

        // Back-pressure on byte 3.
        do_reset();
        stream(3, -1, 1'b0, nb);
        chk("stall_full_count", nb, 32);
        chk("stall_end", {complete, fail}, 2'b10);

        // Reset during byte 10, then restart from address 0.
        do_reset();
        stream(-1, 10, 1'b0, nb);
        chk("rst_progress", nb, 10);
        stream(-1, -1, 1'b0, nb);
        chk("restart_count", nb, 32);
        chk("restart_end", {complete, fail}, 2'b10);

        // cracked dropped mid-stream.
        do_reset();
        stream(-1, -1, 1'b1, nb);
        chk("drop_cr_count", nb, 32);
        chk("drop_cr_end", {complete, fail}, 2'b10);

        // Key display.
        do_reset();
        secret_key = 24'h2FFFFF;
        search_done = 1'b1; cracked = 1'b1;
        tick();
        chk_hex("hex_key_2FFFFF", {7'h24, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
